// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//   Bridges the i2s receiver and the fft core. Incoming i2s samples are
//   truncated to the fft data width and written into one bank of a
//   double-buffered (ping-pong) frame memory. When a bank holds a complete
//   frame and the read side is idle, the banks swap. The completed frame is
//   then streamed to the fft with fft_load/fft_rd, followed by a single
//   fft_start pulse. The read side then waits for fft_done. Capture of the
//   next frame continues in the other bank meanwhile.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-low reset
//   sample_valid  one-cycle strobe, new sample on sample_in
//   sample_in     signed i2s sample (in_width bits)
//   fft_done      fft done flag (level)
//   fft_load      high for exactly N consecutive cycles while a frame streams
//   fft_rd        frame sample for the current load cycle, oldest first
//   fft_start     one-cycle pulse right after the last load cycle
//   busy          read side is not idle
//   overflow      sticky, at least one sample was dropped
module fft_frame_loader #(
  parameter int width    = 16,
  parameter int N_2      = 5,
  parameter int in_width = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [in_width-1:0] sample_in,
  input  logic                fft_done,
  output logic                fft_load,
  output logic [width-1:0]    fft_rd,
  output logic                fft_start,
  output logic                busy,
  output logic                overflow
);

  localparam int N = 1 << N_2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  // Frame memory: address = {bank, index}.
  logic [width-1:0] mem [0:2*N-1];

  // Write side state
  logic           wr_bank_q, wr_bank_d;
  logic [N_2-1:0] wr_idx_q,  wr_idx_d;
  logic           full_q,    full_d;
  logic           overflow_q, overflow_d;

  // Read side state
  state_t         state_q;
  logic           rd_bank_q;
  logic [N_2-1:0] ld_idx_q;
  logic           fft_load_q;
  logic           fft_start_q;
  logic [width-1:0] fft_rd_q;

  logic           swap;
  logic           wr_en;
  logic           drop;
  logic           wr_bank_sel;
  logic [N_2:0]   wr_addr;
  logic [N_2:0]   rd_addr;
  logic [width-1:0] wr_data;

  // A swap hands the full bank to the read side. The write side is already
  // pointing at index 0 (it wrapped when the bank filled), so a sample that
  // arrives in the swap cycle goes straight into index 0 of the new bank.
  assign swap        = full_q && (state_q == S_IDLE);
  assign wr_en       = sample_valid && (!full_q || swap);
  assign drop        = sample_valid && full_q && !swap;
  assign wr_bank_sel = swap ? ~wr_bank_q : wr_bank_q;
  assign wr_addr     = {wr_bank_sel, wr_idx_q};
  assign rd_addr     = {rd_bank_q, ld_idx_q};

  // Keep the top bits; plain truncation keeps the sign bit in place.
  assign wr_data = sample_in[in_width-1 -: width];

  generate
    if (in_width > width) begin : g_lsbs
      logic sample_lsbs_unused;
      assign sample_lsbs_unused = ^sample_in[in_width-width-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_idx_d   = wr_idx_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    if (swap) begin
      wr_bank_d = ~wr_bank_q;
      full_d    = 1'b0;
    end
    if (wr_en) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (&wr_idx_q) begin
        full_d = 1'b1;
      end
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_idx_q   <= wr_idx_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Read FSM. fft_load and fft_rd come from the same edge, so they stay
  // aligned; fft_rd simply holds outside LOAD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      ld_idx_q    <= '0;
      fft_load_q  <= 1'b0;
      fft_start_q <= 1'b0;
      fft_rd_q    <= '0;
    end else begin
      fft_load_q  <= 1'b0;
      fft_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (full_q) begin
            rd_bank_q <= wr_bank_q;
            ld_idx_q  <= '0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          fft_load_q <= 1'b1;
          fft_rd_q   <= mem[rd_addr];
          ld_idx_q   <= ld_idx_q + 1'b1;
          if (&ld_idx_q) begin
            state_q <= S_START;
          end
        end
        S_START: begin
          fft_start_q <= 1'b1;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          // The fft clears done when it is loaded, so a level that is
          // already high here belongs to the frame just sent.
          if (fft_done) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fft_load  = fft_load_q;
  assign fft_rd    = fft_rd_q;
  assign fft_start = fft_start_q;
  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Testbench for fft_frame_loader: scoreboard of expected fft_rd words,
// pushed as samples are sent and popped on every fft_load cycle.
module tb_fft_frame_loader;

  localparam int W   = 16;
  localparam int N_2 = 5;
  localparam int IW  = 24;
  localparam int N   = 1 << N_2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sample_valid = 1'b0;
  logic [IW-1:0] sample_in = '0;
  logic          fft_done = 1'b0;
  logic          fft_load;
  logic [W-1:0]  fft_rd;
  logic          fft_start;
  logic          busy;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int start_count = 0;
  int load_run = 0;
  int load_seen = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] mon_exp;

  fft_frame_loader #(.width(W), .N_2(N_2), .in_width(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .fft_done     (fft_done),
    .fft_load     (fft_load),
    .fft_rd       (fft_rd),
    .fft_start    (fft_start),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Output monitor: one line per streamed word.
  always @(negedge clk) begin
    if (reset) begin
      if (fft_load === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL load_unexpected: fft_rd=%h with no expected sample", fft_rd);
        end else begin
          mon_exp = exp_q.pop_front();
          if (fft_rd !== mon_exp) begin
            errors++;
            $display("FAIL load_data[%0d]: fft_rd=%h required %h", load_run, fft_rd, mon_exp);
          end else begin
            $display("load[%0d] fft_rd=%h ok", load_run, fft_rd);
          end
        end
        checks++;
        if (fft_start !== 1'b0) begin
          errors++;
          $display("FAIL load_start_overlap: fft_start=%b required 0", fft_start);
        end
        load_run++;
        load_seen++;
      end else if (fft_start === 1'b1) begin
        start_count++;
        checks++;
        if (load_run != N) begin
          errors++;
          $display("FAIL start_after_load: load run=%0d required %0d", load_run, N);
        end else begin
          $display("start pulse %0d after %0d loads", start_count, load_run);
        end
        load_run = 0;
      end else if (load_run != 0) begin
        checks++;
        errors++;
        $display("FAIL load_run_no_start: run=%0d ended without fft_start", load_run);
        load_run = 0;
      end
    end else begin
      load_run = 0;
    end
  end

  task automatic send(input logic [IW-1:0] v, input logic [W-1:0] e, input bit accept);
    sample_valid = 1'b1;
    sample_in    = v;
    if (accept) exp_q.push_back(e);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_rand(input bit accept);
    logic [IW-1:0] v;
    v = IW'($urandom);
    send(v, v[IW-1 -: W], accept);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (start_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (start_count < target) begin
      errors++;
      $display("FAIL %s_timeout: starts=%0d required %0d", tag, start_count, target);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (fft_load !== 1'b0) begin errors++; $display("FAIL reset_fft_load: %b required 0", fft_load); end
    if (fft_rd !== '0) begin errors++; $display("FAIL reset_fft_rd: %h required 0000", fft_rd); end
    if (fft_start !== 1'b0) begin errors++; $display("FAIL reset_fft_start: %b required 0", fft_start); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: %b required 0", overflow); end
    $display("reset state checked");
    align();
    reset = 1'b1;
  endtask

  task automatic test_basic_frame();
    int base;
    base = start_count;
    align();
    fft_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      send({16'(k), 8'hA5}, 16'(k), 1'b1);
    end
    // Now just after the edge that set full.
    @(negedge clk);
    checks += 2;
    if (fft_load !== 1'b0) begin errors++; $display("FAIL latency_c0_load: %b required 0", fft_load); end
    if (busy !== 1'b0) begin errors++; $display("FAIL latency_c0_busy: %b required 0", busy); end
    @(negedge clk);
    checks += 2;
    if (fft_load !== 1'b0) begin errors++; $display("FAIL latency_c1_load: %b required 0", fft_load); end
    if (busy !== 1'b1) begin errors++; $display("FAIL latency_c1_busy: %b required 1", busy); end
    @(negedge clk);
    checks += 2;
    if (fft_load !== 1'b1) begin errors++; $display("FAIL latency_c2_load: %b required 1", fft_load); end
    if (busy !== 1'b1) begin errors++; $display("FAIL load_busy: %b required 1", busy); end
    wait_starts(base + 1, 100, "basic");
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy: %b required 1", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: %b required 0", overflow); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_leftover: %0d words required 0", exp_q.size()); end
    fft_done = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_busy: %b required 0", busy); end
    fft_done = 1'b0;
  endtask

  task automatic test_sign();
    int base;
    base = start_count;
    align();
    fft_done = 1'b1;
    send(24'h800000, 16'h8000, 1'b1);
    send(24'hFFFFFF, 16'hFFFF, 1'b1);
    for (int k = 2; k < N; k++) send_rand(1'b1);
    wait_starts(base + 1, 100, "sign");
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sign_leftover: %0d words required 0", exp_q.size()); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overflow();
    int base;
    base = start_count;
    align();
    fft_done = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_initial: %b required 0", overflow); end
    for (int k = 0; k < 2 * N; k++) send_rand(1'b1);
    for (int k = 0; k < 8; k++) send_rand(1'b0);
    @(negedge clk);
    checks += 2;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: %b required 1", overflow); end
    if (exp_q.size() != N) begin errors++; $display("FAIL ovf_pending: %0d words required %0d", exp_q.size(), N); end
    wait_starts(base + 1, 100, "ovf_first");
    fft_done = 1'b1;
    wait_starts(base + 2, 200, "ovf_second");
    repeat (3) @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_leftover: %0d words required 0", exp_q.size()); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: %b required 1", overflow); end
    fft_done = 1'b0;
    do_reset();
  endtask

  task automatic test_swap_coincident();
    int base;
    base = start_count;
    align();
    fft_done = 1'b1;
    for (int k = 0; k < N; k++) send_rand(1'b1);
    send(24'h123400, 16'h1234, 1'b1);  // lands in the swap cycle
    for (int k = 1; k < N; k++) send_rand(1'b1);
    wait_starts(base + 2, 300, "swap");
    repeat (3) @(negedge clk);
    checks += 2;
    if (overflow !== 1'b0) begin errors++; $display("FAIL swap_overflow: %b required 0", overflow); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL swap_leftover: %0d words required 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    int base;
    int n;
    do_reset();
    fft_done = 1'b0;
    align();
    for (int k = 0; k < N; k++) send_rand(1'b1);
    n = 0;
    while (fft_load !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (fft_load !== 1'b1) begin errors++; $display("FAIL abort_load_timeout: fft_load=%b required 1", fft_load); end
    // First load cycle visible: load index register is 1. Advance to 10.
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    base = start_count;
    @(negedge clk);
    checks += 3;
    if (fft_load !== 1'b0) begin errors++; $display("FAIL abort_load: %b required 0", fft_load); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: %b required 0", busy); end
    if (fft_start !== 1'b0) begin errors++; $display("FAIL abort_start: %b required 0", fft_start); end
    repeat (50) @(negedge clk);
    checks++;
    if (start_count != base) begin errors++; $display("FAIL abort_no_start: starts=%0d required %0d", start_count, base); end
    align();
    for (int k = 0; k < N; k++) send_rand(1'b1);
    wait_starts(base + 1, 100, "abort_clean");
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL abort_leftover: %0d words required 0", exp_q.size()); end
    fft_done = 1'b1;
    repeat (3) @(negedge clk);
    fft_done = 1'b0;
  endtask

  task automatic test_steady_state();
    int base;
    int loads0;
    do_reset();
    fft_done = 1'b0;
    base = start_count;
    loads0 = load_seen;
    align();
    fork
      begin
        for (int i = 0; i < 4 * N; i++) begin
          send_rand(1'b1);
          repeat (7) @(posedge clk);
          #1;
        end
      end
      begin
        for (int f = 0; f < 4; f++) begin
          wait_starts(base + f + 1, 1500, "steady");
          repeat (100) @(posedge clk);
          #1;
          fft_done = 1'b1;
          @(posedge clk);
          #1;
          fft_done = 1'b0;
        end
      end
    join
    repeat (3) @(negedge clk);
    checks += 4;
    if (overflow !== 1'b0) begin errors++; $display("FAIL steady_overflow: %b required 0", overflow); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL steady_leftover: %0d words required 0", exp_q.size()); end
    if (start_count != base + 4) begin errors++; $display("FAIL steady_starts: %0d required %0d", start_count - base, 4); end
    if (load_seen - loads0 != 4 * N) begin errors++; $display("FAIL steady_loads: %0d required %0d", load_seen - loads0, 4 * N); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_sign();
    test_overflow();
    test_swap_coincident();
    test_reset_abort();
    test_steady_state();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
